// File: rtl/p_s_converter_pkg.sv
// Shared types and helpers for the parallel-to-serial converter.
// Frame state is a single bit: each frame is either carrying a word or idle.
package p_s_converter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } frame_state_e;

  localparam logic [7:0] IDLE_CNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == IDLE_CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/p_s_converter_frame_counter.sv
// Free-running bit counter that wraps every C_BITS cycles and marks frame edges.
// Reset parks it on the last slot so the first live edge is a frame boundary.
module frame_counter #(
  parameter  int C_BITS = 255,
  localparam int CW     = $clog2(C_BITS)
) (
  input  logic          CK,
  input  logic          RST,
  output logic [CW-1:0] bit_cnt,
  output logic          at_boundary,
  output logic          at_start
);

  localparam logic [CW-1:0] LAST = CW'(C_BITS - 1);

  logic [CW-1:0] r_bit_cnt;

  always_ff @(posedge CK) begin
    if (!RST) begin
      r_bit_cnt <= LAST;
    end else if (r_bit_cnt == LAST) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + CW'(1);
    end
  end

  assign bit_cnt     = r_bit_cnt;
  assign at_boundary = (r_bit_cnt == LAST);
  assign at_start    = (r_bit_cnt == '0);

endmodule

// File: rtl/p_s_converter.sv
// Parallel-to-serial converter: shifts one C_BITS word out MSB first per fixed frame,
// emitting an idle frame whenever no word is offered at the frame boundary.
module p_s_converter
  import p_s_converter_pkg::*;
#(
  parameter  int   C_BITS   = 255,
  parameter  logic IDLE_BIT = 1'b0,
  localparam int   CW       = $clog2(C_BITS)
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [C_BITS-1:0] DIN,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  output logic              SDO,
  output logic              FRAME_START,
  output logic              FRAME_VALID,
  output logic [7:0]        IDLE_CNT,
  output logic [CW-1:0]     o_dbg_bit_cnt,
  output frame_state_e      o_dbg_state
);

  // Handshake: a word transfers on a rising edge where LOAD_VALID and LOAD_READY are
  // both high. LOAD_READY is a pure state decode (the boundary slot), never a function
  // of LOAD_VALID; the source holds DIN/LOAD_VALID until it sees LOAD_READY.

  logic [C_BITS-1:0] r_sr;
  logic [7:0]        r_idle_cnt;
  frame_state_e      r_state;
  frame_state_e      w_state_nxt;
  logic [CW-1:0]     w_bit_cnt;
  logic              w_at_boundary;
  logic              w_at_start;

  frame_counter #(.C_BITS(C_BITS)) u_frame_counter (
    .CK          (CK),
    .RST         (RST),
    .bit_cnt     (w_bit_cnt),
    .at_boundary (w_at_boundary),
    .at_start    (w_at_start)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_at_boundary) begin
      w_state_nxt = LOAD_VALID ? ST_DATA : ST_IDLE;
    end
  end

  always_ff @(posedge CK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge CK) begin
    if (!RST) begin
      r_sr       <= {C_BITS{IDLE_BIT}};
      r_idle_cnt <= '0;
    end else if (w_at_boundary) begin
      if (LOAD_VALID) begin
        r_sr <= DIN;
      end else begin
        r_sr       <= {C_BITS{IDLE_BIT}};
        r_idle_cnt <= sat_inc8(r_idle_cnt);
      end
    end else begin
      r_sr <= {r_sr[C_BITS-2:0], IDLE_BIT};
    end
  end

  assign SDO           = r_sr[C_BITS-1];
  assign LOAD_READY    = w_at_boundary;
  assign FRAME_START   = w_at_start;
  assign FRAME_VALID   = (r_state == ST_DATA);
  assign IDLE_CNT      = r_idle_cnt;
  assign o_dbg_bit_cnt = w_bit_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_p_s_converter.sv
// Bench for p_s_converter (C_BITS = 8): frame-level reference model, scoreboard of
// accepted words checked against the deserialised SDO stream, one task per scenario.
module tb_p_s_converter;
  import p_s_converter_pkg::*;

  localparam int   C        = 8;
  localparam logic IDLE_BIT = 1'b0;
  localparam int   CW       = $clog2(C);

  logic          CK = 1'b0;
  logic          RST = 1'b0;
  logic          LOAD_VALID = 1'b0;
  logic [C-1:0]  DIN = '0;
  logic          LOAD_READY, SDO, FRAME_START, FRAME_VALID;
  logic [7:0]    IDLE_CNT;
  logic [CW-1:0] o_dbg_bit_cnt;
  frame_state_e  o_dbg_state;

  int tests = 0;
  int fails = 0;

  // reference model: n = edges since reset release, frame = (n-1)/C, slot = (n-1)%C
  int           n = 0;
  logic         cur_data = 1'b0;
  logic [C-1:0] cur_word = '0;
  int           idle_frames = 0;
  logic [C-1:0] exp_q[$];
  logic         exp_sdo, exp_fs, exp_fv, exp_ready;
  logic [7:0]   exp_idle;
  logic [C-1:0] rx_word = '0;
  logic         rx_done = 1'b0;

  p_s_converter #(.C_BITS(C), .IDLE_BIT(IDLE_BIT)) dut (
    .CK            (CK),
    .RST           (RST),
    .DIN           (DIN),
    .LOAD_VALID    (LOAD_VALID),
    .LOAD_READY    (LOAD_READY),
    .SDO           (SDO),
    .FRAME_START   (FRAME_START),
    .FRAME_VALID   (FRAME_VALID),
    .IDLE_CNT      (IDLE_CNT),
    .o_dbg_bit_cnt (o_dbg_bit_cnt),
    .o_dbg_state   (o_dbg_state)
  );

  always #5 CK = ~CK;

  // advance one clock and update the model; inputs are stable at the edge
  task automatic tick();
    logic         rst_s, lv_s;
    logic [C-1:0] din_s;
    int           k;
    rst_s = RST;
    lv_s  = LOAD_VALID;
    din_s = DIN;
    @(posedge CK);
    #1;
    if (!rst_s) begin
      n = 0;
      cur_data = 1'b0;
      idle_frames = 0;
      exp_q.delete();
    end else begin
      if (n % C == 0) begin
        if (lv_s) begin
          cur_word = din_s;
          cur_data = 1'b1;
          exp_q.push_back(din_s);
        end else begin
          cur_data = 1'b0;
          idle_frames++;
        end
      end
      n++;
    end
    k = (n == 0) ? 0 : (n - 1) % C;
    exp_sdo   = (n > 0 && cur_data) ? cur_word[C-1-k] : IDLE_BIT;
    exp_fs    = (n > 0 && k == 0);
    exp_fv    = (n > 0) && cur_data;
    exp_ready = (n % C == 0);
    exp_idle  = (idle_frames > 255) ? 8'd255 : 8'(idle_frames);
    rx_done = 1'b0;
    if (n > 0 && cur_data) begin
      rx_word = {rx_word[C-2:0], SDO};
      if (k == C - 1) rx_done = 1'b1;
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    LOAD_VALID = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    LOAD_VALID = 1'b1;
    DIN = C'($urandom);
    repeat (3) tick();
    LOAD_VALID = 1'b0;
    tests++; if (SDO !== IDLE_BIT) begin fails++; $display("FAIL reset_sdo: got %0b expected %0b", SDO, IDLE_BIT); end
    tests++; if (LOAD_READY !== 1'b1) begin fails++; $display("FAIL reset_ready: got %0b expected 1", LOAD_READY); end
    tests++; if (FRAME_START !== 1'b0) begin fails++; $display("FAIL reset_fs: got %0b expected 0", FRAME_START); end
    tests++; if (FRAME_VALID !== 1'b0) begin fails++; $display("FAIL reset_fv: got %0b expected 0", FRAME_VALID); end
    tests++; if (IDLE_CNT !== 8'd0) begin fails++; $display("FAIL reset_idle_cnt: got %0d expected 0", IDLE_CNT); end
    tests++; if (o_dbg_bit_cnt !== CW'(C - 1)) begin fails++; $display("FAIL reset_bit_cnt: got %0d expected %0d", o_dbg_bit_cnt, C - 1); end
  endtask

  task automatic test_idle_frames();
    do_reset();
    repeat (4 * C) begin
      tick();
      tests++; if (SDO !== exp_sdo) begin fails++; $display("FAIL idle_sdo n=%0d: got %0b expected %0b", n, SDO, exp_sdo); end
      tests++; if (FRAME_START !== exp_fs) begin fails++; $display("FAIL idle_fs n=%0d: got %0b expected %0b", n, FRAME_START, exp_fs); end
      tests++; if (FRAME_VALID !== 1'b0) begin fails++; $display("FAIL idle_fv n=%0d: got %0b expected 0", n, FRAME_VALID); end
      tests++; if (LOAD_READY !== exp_ready) begin fails++; $display("FAIL idle_ready n=%0d: got %0b expected %0b", n, LOAD_READY, exp_ready); end
    end
    tests++; if (IDLE_CNT !== 8'd4) begin fails++; $display("FAIL idle_cnt4: got %0d expected 4", IDLE_CNT); end
  endtask

  task automatic test_single_word();
    logic [7:0] seq;
    seq = 8'hA5;
    do_reset();
    LOAD_VALID = 1'b1;
    DIN = seq;
    for (int i = 0; i < C; i++) begin
      tick();
      LOAD_VALID = 1'b0;
      tests++; if (SDO !== seq[7-i]) begin fails++; $display("FAIL a5_sdo bit%0d: got %0b expected %0b", i, SDO, seq[7-i]); end
      tests++; if (FRAME_VALID !== 1'b1) begin fails++; $display("FAIL a5_fv bit%0d: got %0b expected 1", i, FRAME_VALID); end
    end
    tests++;
    if (!rx_done || exp_q.size() == 0) begin
      fails++; $display("FAIL a5_rx: got no complete word, expected %0h", seq);
    end else if (rx_word !== exp_q.pop_front()) begin
      fails++; $display("FAIL a5_rx: got %0h expected %0h", rx_word, seq);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words[2];
    int idx, ready_cnt;
    logic r;
    words[0] = 8'h01;
    words[1] = 8'hFF;
    idx = 0;
    ready_cnt = 0;
    do_reset();
    for (int i = 0; i < 2 * C; i++) begin
      LOAD_VALID = (idx < 2);
      DIN = (idx < 2) ? words[idx] : '0;
      r = LOAD_READY;
      if (r) ready_cnt++;
      tick();
      if (r && idx < 2) idx++;
      tests++; if (FRAME_VALID !== 1'b1) begin fails++; $display("FAIL b2b_fv cyc%0d: got %0b expected 1", i, FRAME_VALID); end
      tests++; if (SDO !== exp_sdo) begin fails++; $display("FAIL b2b_sdo cyc%0d: got %0b expected %0b", i, SDO, exp_sdo); end
      if (rx_done) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL b2b_rx: got %0h expected nothing", rx_word); end
        else if (rx_word !== exp_q[0]) begin fails++; $display("FAIL b2b_rx: got %0h expected %0h", rx_word, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
    end
    LOAD_VALID = 1'b0;
    tests++; if (ready_cnt != 2) begin fails++; $display("FAIL b2b_ready_cnt: got %0d expected 2", ready_cnt); end
  endtask

  task automatic test_late_valid();
    int cycles;
    logic accepted, r;
    logic [C-1:0] w;
    w = C'($urandom_range(1, 255));
    do_reset();
    repeat (4) tick();
    tests++; if (o_dbg_bit_cnt !== CW'(3)) begin fails++; $display("FAIL late_bit_cnt: got %0d expected 3", o_dbg_bit_cnt); end
    LOAD_VALID = 1'b1;
    DIN = w;
    cycles = 0;
    accepted = 1'b0;
    while (!accepted && cycles < 20) begin
      r = LOAD_READY;
      tick();
      cycles++;
      if (r) accepted = 1'b1;
      tests++; if (FRAME_VALID !== exp_fv) begin fails++; $display("FAIL late_fv cyc%0d: got %0b expected %0b", cycles, FRAME_VALID, exp_fv); end
      tests++; if (SDO !== exp_sdo) begin fails++; $display("FAIL late_sdo cyc%0d: got %0b expected %0b", cycles, SDO, exp_sdo); end
    end
    LOAD_VALID = 1'b0;
    tests++; if (cycles != 5) begin fails++; $display("FAIL late_latency: got %0d cycles expected 5", cycles); end
    repeat (C - 1) begin
      tick();
      tests++; if (SDO !== exp_sdo) begin fails++; $display("FAIL late_data_sdo n=%0d: got %0b expected %0b", n, SDO, exp_sdo); end
    end
    tests++;
    if (!rx_done) begin fails++; $display("FAIL late_rx: got no complete word, expected %0h", w); end
    else if (rx_word !== w) begin fails++; $display("FAIL late_rx: got %0h expected %0h", rx_word, w); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    LOAD_VALID = 1'b1;
    DIN = 8'hFF;
    tick();
    LOAD_VALID = 1'b0;
    repeat (4) tick();
    tests++; if (o_dbg_bit_cnt !== CW'(4)) begin fails++; $display("FAIL mid_bit_cnt: got %0d expected 4", o_dbg_bit_cnt); end
    RST = 1'b0;
    tick();
    tests++; if (SDO !== IDLE_BIT) begin fails++; $display("FAIL mid_sdo: got %0b expected %0b", SDO, IDLE_BIT); end
    tests++; if (LOAD_READY !== 1'b1) begin fails++; $display("FAIL mid_ready: got %0b expected 1", LOAD_READY); end
    tests++; if (FRAME_VALID !== 1'b0) begin fails++; $display("FAIL mid_fv: got %0b expected 0", FRAME_VALID); end
    tests++; if (IDLE_CNT !== 8'd0) begin fails++; $display("FAIL mid_idle_cnt: got %0d expected 0", IDLE_CNT); end
    RST = 1'b1;
  endtask

  task automatic test_idle_saturation();
    do_reset();
    repeat (300 * C) begin
      tick();
      if (exp_fs) begin
        tests++; if (IDLE_CNT !== exp_idle) begin fails++; $display("FAIL sat_idle_cnt n=%0d: got %0d expected %0d", n, IDLE_CNT, exp_idle); end
      end
    end
    tests++; if (IDLE_CNT !== 8'd255) begin fails++; $display("FAIL sat_final: got %0d expected 255", IDLE_CNT); end
  endtask

  task automatic test_random();
    do_reset();
    repeat (40 * C) begin
      if (n % C == 0) begin
        LOAD_VALID = 1'($urandom_range(0, 1));
        DIN = C'($urandom);
      end
      tick();
      tests++; if (SDO !== exp_sdo) begin fails++; $display("FAIL rnd_sdo n=%0d: got %0b expected %0b", n, SDO, exp_sdo); end
      tests++; if (FRAME_START !== exp_fs) begin fails++; $display("FAIL rnd_fs n=%0d: got %0b expected %0b", n, FRAME_START, exp_fs); end
      tests++; if (FRAME_VALID !== exp_fv) begin fails++; $display("FAIL rnd_fv n=%0d: got %0b expected %0b", n, FRAME_VALID, exp_fv); end
      tests++; if (LOAD_READY !== exp_ready) begin fails++; $display("FAIL rnd_ready n=%0d: got %0b expected %0b", n, LOAD_READY, exp_ready); end
      tests++; if (IDLE_CNT !== exp_idle) begin fails++; $display("FAIL rnd_idle_cnt n=%0d: got %0d expected %0d", n, IDLE_CNT, exp_idle); end
      if (rx_done) begin
        tests++;
        if (exp_q.size() == 0) begin fails++; $display("FAIL rnd_rx: got %0h expected nothing", rx_word); end
        else if (rx_word !== exp_q[0]) begin fails++; $display("FAIL rnd_rx: got %0h expected %0h", rx_word, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
      end
    end
    LOAD_VALID = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_single_word();
    test_back_to_back();
    test_late_valid();
    test_reset_mid_frame();
    test_idle_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
